sr_cmd_driver: RTL and testbench

Upstream command stage for the `srff` SR flip-flop. It accepts set, reset, toggle and no-op commands over a valid/ready handshake and converts each into a registered, glitch-free pulse on `s` or `r`. Each pulse lasts a programmable number of clocks and is followed by a mandatory all-low gap. The forbidden `s=r=1` input combination is therefore structurally impossible. The block also keeps a shadow copy of the flip-flop state, so toggle commands can be resolved internally.

---
 rtl/sr_cmd_driver_if.sv | 28 ++
 rtl/sr_cmd_driver.sv | 103 ++++++++++
 tb/tb_sr_cmd_driver.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_cmd_driver_if.sv
// +-----------------------------------------------------------------------+
// | sr_cmd_driver_if : command handshake and SR drive bundle              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface sr_cmd_driver_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       s;
  logic       r;
  logic       q_shadow;
  logic       busy;
  logic [7:0] cmd_count;

  modport master (
    output cmd_valid, cmd_op,
    input  cmd_ready, s, r, q_shadow, busy, cmd_count
  );

  modport slave (
    input  cmd_valid, cmd_op,
    output cmd_ready, s, r, q_shadow, busy, cmd_count
  );
endinterface

`default_nettype wire

// File: rtl/sr_cmd_driver.sv
// +-----------------------------------------------------------------------+
// | sr_cmd_driver : turns SET/RESET/TOGGLE/NOP commands into timed,       |
// | mutually exclusive s/r pulses followed by an all-low gap. Rev 1.0     |
// +-----------------------------------------------------------------------+
`default_nettype none

module sr_cmd_driver #(
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_cmd_driver_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] c_op_nop    = 2'b00;
  localparam logic [1:0] c_op_set    = 2'b01;
  localparam logic [1:0] c_op_toggle = 2'b11;
  localparam logic [7:0] c_hold_load = 8'(HOLD_CYC - 1);
  localparam logic [7:0] c_gap_load  = 8'(GAP_CYC - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_s;
  logic       r_r;
  logic       r_q;
  logic       r_busy;
  logic [7:0] r_count;

  logic w_accept;
  logic w_drive_set;

  // NOPs never leave IDLE, so only real commands count as acceptances here.
  assign w_accept    = bus.cmd_valid && (r_state == IDLE) && (bus.cmd_op != c_op_nop);
  assign w_drive_set = (bus.cmd_op == c_op_set) ||
                       ((bus.cmd_op == c_op_toggle) && !r_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_q     <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= DRIVE;
            r_s     <= w_drive_set;
            r_r     <= !w_drive_set;
            r_cnt   <= c_hold_load;
            r_busy  <= 1'b1;
            r_count <= r_count + 8'd1;
          end
        end
        DRIVE: begin
          if (r_cnt == 8'd0) begin
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_q     <= r_s;
            r_cnt   <= c_gap_load;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        GAP: begin
          if (r_cnt == 8'd0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.s         = r_s;
  assign bus.r         = r_r;
  assign bus.q_shadow  = r_q;
  assign bus.busy      = r_busy;
  assign bus.cmd_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_sr_cmd_driver.sv
// +-----------------------------------------------------------------------+
// | tb_sr_cmd_driver : randomized self-checking bench with a timing-rule  |
// | reference model (HOLD_CYC=2, GAP_CYC=1). Rev 1.0                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_sr_cmd_driver;
  localparam int H = 2;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sr_cmd_driver_if bus ();

  sr_cmd_driver #(.HOLD_CYC(H), .GAP_CYC(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp;
  int n_fail;
  int e;

  // Model: last accepted command's edge index and resolved polarity.
  int         m_acc;
  bit         m_set;
  bit         m_q_prev;
  logic [7:0] m_count;
  bit         accepted;
  logic exp_s, exp_r, exp_busy, exp_ready, exp_q;

  function automatic void model_reset();
    m_acc    = -1000;
    m_set    = 1'b0;
    m_q_prev = 1'b0;
    m_count  = 8'd0;
  endfunction

  function automatic void model_eval(int t);
    bit in_cmd;
    bit in_drive;
    in_cmd    = (t >= m_acc) && (t < m_acc + H + G);
    in_drive  = (t >= m_acc) && (t < m_acc + H);
    exp_busy  = in_cmd;
    exp_ready = !in_cmd;
    exp_s     = in_drive && m_set;
    exp_r     = in_drive && !m_set;
    exp_q     = (t >= m_acc + H) ? m_set : m_q_prev;
  endfunction

  task automatic clk_step();
    model_eval(e);
    accepted = 1'b0;
    if (rst_n && bus.cmd_valid && exp_ready && (bus.cmd_op != 2'b00)) begin
      m_q_prev = exp_q;
      m_set    = (bus.cmd_op == 2'b01) || ((bus.cmd_op == 2'b11) && !exp_q);
      m_acc    = e + 1;
      m_count  = m_count + 8'd1;
      accepted = 1'b1;
    end
    @(posedge clk);
    e++;
    #1;
    model_eval(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    model_reset();
    repeat (2) clk_step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    rst_n = 1'b0;
    model_reset();
    repeat (3) clk_step();
    n_cmp++;
    if ({bus.s, bus.r, bus.q_shadow, bus.busy, bus.cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_outputs: s,r,q,busy,ready=%b expected 00001",
               {bus.s, bus.r, bus.q_shadow, bus.busy, bus.cmd_ready});
    end
    n_cmp++;
    if (bus.cmd_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", bus.cmd_count);
    end
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_set();
    int hi;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    clk_step();
    bus.cmd_valid = 1'b0;
    hi = (bus.s === 1'b1) ? 1 : 0;
    n_cmp++;
    if (bus.s !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL set_start: s=%b ready=%b expected s=1 ready=0", bus.s, bus.cmd_ready);
    end
    for (int i = 0; i < 5; i++) begin
      clk_step();
      if (bus.s === 1'b1) hi++;
      n_cmp++;
      if ({bus.s, bus.r, bus.q_shadow, bus.cmd_ready} !== {exp_s, exp_r, exp_q, exp_ready}) begin
        n_fail++;
        $display("FAIL set_cycle%0d: s,r,q,ready=%b expected %b", i,
                 {bus.s, bus.r, bus.q_shadow, bus.cmd_ready}, {exp_s, exp_r, exp_q, exp_ready});
      end
    end
    n_cmp++;
    if (hi != H) begin
      n_fail++;
      $display("FAIL set_pulse_len: got %0d cycles expected %0d", hi, H);
    end
    n_cmp++;
    if (bus.q_shadow !== 1'b1 || bus.cmd_count !== 8'd1 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL set_final: q=%b count=%0d ready=%b expected q=1 count=1 ready=1",
               bus.q_shadow, bus.cmd_count, bus.cmd_ready);
    end
  endtask

  task automatic test_toggle_seq();
    string seq;
    int    rise[$];
    int    n_acc;
    logic  prev_s, prev_r;
    do_reset();
    seq = "";
    n_acc = 0;
    prev_s = 1'b0;
    prev_r = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    for (int i = 0; i < 16; i++) begin
      clk_step();
      if (accepted) n_acc++;
      if (n_acc == 3) bus.cmd_valid = 1'b0;
      if (bus.s && !prev_s) begin seq = {seq, "s"}; rise.push_back(e); end
      if (bus.r && !prev_r) begin seq = {seq, "r"}; rise.push_back(e); end
      prev_s = bus.s;
      prev_r = bus.r;
      n_cmp++;
      if ((bus.s & bus.r) !== 1'b0) begin
        n_fail++;
        $display("FAIL toggle_overlap: s=%b r=%b at edge %0d", bus.s, bus.r, e);
      end
    end
    n_cmp++;
    if (seq != "srs") begin
      n_fail++;
      $display("FAIL toggle_order: got '%s' expected 'srs'", seq);
    end
    n_cmp++;
    if (rise.size() != 3) begin
      n_fail++;
      $display("FAIL toggle_pulses: got %0d pulses expected 3", rise.size());
    end else if ((rise[1] - rise[0] != H + G + 1) || (rise[2] - rise[1] != H + G + 1)) begin
      n_fail++;
      $display("FAIL toggle_spacing: got %0d,%0d expected %0d", rise[1] - rise[0],
               rise[2] - rise[1], H + G + 1);
    end
    n_cmp++;
    if (bus.q_shadow !== 1'b1 || bus.cmd_count !== 8'd3) begin
      n_fail++;
      $display("FAIL toggle_final: q=%b count=%0d expected q=1 count=3",
               bus.q_shadow, bus.cmd_count);
    end
  endtask

  task automatic test_nop_backpressure();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      n_cmp++;
      if ({bus.cmd_ready, bus.busy, bus.s, bus.r} !== 4'b1000 || bus.cmd_count !== m_count) begin
        n_fail++;
        $display("FAIL nop_cycle%0d: ready,busy,s,r=%b count=%0d expected 1000 count=%0d", i,
                 {bus.cmd_ready, bus.busy, bus.s, bus.r}, bus.cmd_count, m_count);
      end
    end
    bus.cmd_op = 2'b10;
    clk_step();
    for (int i = 0; i < 5; i++) begin
      if (i < 2) begin
        bus.cmd_op = (i == 0) ? 2'b01 : 2'b11;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      n_cmp++;
      if ({bus.s, bus.r, bus.q_shadow, bus.busy} !== {exp_s, exp_r, exp_q, exp_busy} ||
          bus.s !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_cycle%0d: s,r,q,busy=%b expected %b", i,
                 {bus.s, bus.r, bus.q_shadow, bus.busy}, {exp_s, exp_r, exp_q, exp_busy});
      end
      clk_step();
    end
    n_cmp++;
    if (bus.q_shadow !== 1'b0 || bus.cmd_count !== m_count) begin
      n_fail++;
      $display("FAIL backpressure_final: q=%b count=%0d expected q=0 count=%0d",
               bus.q_shadow, bus.cmd_count, m_count);
    end
  endtask

  task automatic test_reset_mid_drive();
    int hi;
    do_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    clk_step();
    bus.cmd_valid = 1'b0;
    clk_step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({bus.s, bus.r, bus.q_shadow, bus.busy, bus.cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL async_reset: s,r,q,busy,ready=%b expected 00001",
               {bus.s, bus.r, bus.q_shadow, bus.busy, bus.cmd_ready});
    end
    repeat (2) clk_step();
    rst_n = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    clk_step();
    bus.cmd_valid = 1'b0;
    hi = (bus.r === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      clk_step();
      if (bus.r === 1'b1) hi++;
      n_cmp++;
      if (bus.s !== 1'b0 || bus.r !== exp_r) begin
        n_fail++;
        $display("FAIL post_reset_cycle%0d: s=%b r=%b expected s=0 r=%b", i, bus.s, bus.r, exp_r);
      end
    end
    n_cmp++;
    if (hi != H) begin
      n_fail++;
      $display("FAIL post_reset_r_len: got %0d cycles expected %0d", hi, H);
    end
  endtask

  task automatic test_counter_wrap();
    int n;
    do_reset();
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    for (int i = 0; i < 1100 && n < 256; i++) begin
      clk_step();
      if (accepted) n++;
      n_cmp++;
      if (bus.cmd_count !== m_count) begin
        n_fail++;
        $display("FAIL wrap_count: got %0d expected %0d after %0d commands", bus.cmd_count, m_count, n);
      end
      if (accepted && n == 255) begin
        n_cmp++;
        if (bus.cmd_count !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_255: got %0d expected 255", bus.cmd_count);
        end
      end
      if (accepted && n == 256) begin
        n_cmp++;
        if (bus.cmd_count !== 8'd0) begin
          n_fail++;
          $display("FAIL wrap_256: got %0d expected 0", bus.cmd_count);
        end
      end
    end
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if (n != 256) begin
      n_fail++;
      $display("FAIL wrap_accepts: got %0d accepted expected 256 within cycle budget", n);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_op    = 2'($urandom_range(0, 3));
      clk_step();
      n_cmp++;
      if ({bus.s, bus.r, bus.busy, bus.cmd_ready, bus.q_shadow} !==
          {exp_s, exp_r, exp_busy, exp_ready, exp_q}) begin
        n_fail++;
        $display("FAIL random_outputs edge %0d: s,r,busy,ready,q=%b expected %b", e,
                 {bus.s, bus.r, bus.busy, bus.cmd_ready, bus.q_shadow},
                 {exp_s, exp_r, exp_busy, exp_ready, exp_q});
      end
      n_cmp++;
      if (bus.cmd_count !== m_count) begin
        n_fail++;
        $display("FAIL random_count edge %0d: got %0d expected %0d", e, bus.cmd_count, m_count);
      end
    end
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    e      = 0;
    rst_n  = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    model_reset();
    #1;
    test_reset();
    test_set();
    test_toggle_seq();
    test_nop_backpressure();
    test_reset_mid_drive();
    test_counter_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
